jtag_host_driver: RTL and testbench
===================================

Name: jtag_host_driver

Overview:
- Clocked JTAG initiator that drives a TAP's TCK/TMS/TDI and samples TDO.
- Runs the TAP state sequences that produce the capture/shift/update pulses consumed by the boundary scan chain.
- Used as the stimulus/control end of the scan path, so IR/DR scans are issued as single commands.
- Host side: valid/ready command channel plus a one-cycle response pulse carrying the captured TDO bits.

Parameters:
- MAX_LEN, 32, maximum scan length in bits; width of cmd_data/rsp_data.
- CLK_DIV, 2, clk cycles per TCK half-period; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  driver can accept a command
- cmd_type  in  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 idle run
- cmd_len  in  $clog2(MAX_LEN)+1  bit count (scan) or TCK count (idle)
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first
- rsp_valid  out  1  one-cycle pulse, command complete
- rsp_data  out  MAX_LEN  captured TDO bits; first bit at [0], zero above len
- busy  out  1  high whenever not in IDLE
- TCK  out  1  test clock
- TMS  out  1  test mode select
- TDI  out  1  test data in (to TAP)
- TDO  in  1  test data out (from TAP)

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1. Internal state goes to INIT.
- TCK timing:
  - Each TCK period is a low phase of CLK_DIV clk cycles followed by a high phase of CLK_DIV clk cycles.
  - TCK is held 0 in IDLE.
  - TMS/TDI change only on the clk edge that starts a low phase.
  - TDO is registered on the clk edge that drives TCK 0→1.
- States: INIT, IDLE, PRE, SHIFT, POST, DONE.
- INIT:
  - 5 TCK periods with TMS=1 (Test-Logic-Reset), then 1 period with TMS=0 (Run-Test/Idle).
  - Then go to IDLE. No rsp_valid is generated for INIT.
- IDLE:
  - cmd_ready=1. A transfer occurs when cmd_valid and cmd_ready are both high.
  - cmd_type, len and data are latched on the transfer. cmd_ready drops the next cycle.
- PRE (TMS per TCK period):
  - IR scan: 1,1,0,0.
  - DR scan: 1,0,0.
  - TAP reset: 1,1,1,1,1,0, then DONE.
  - Idle run: len periods of TMS=0, then DONE.
- SHIFT:
  - len TCK periods. TDI = data[i] for period i.
  - TMS=0 for periods 0..len-2 and TMS=1 for period len-1 (to Exit1).
  - TDO sampled on period i's rising edge goes to rsp_data[i].
- POST: TMS 1 (Update), then 0 (Run-Test/Idle).
- Total TCK periods per command: IR = 4+len+2; DR = 3+len+2.
- DONE:
  - Entered after the final TCK falling edge; TCK=0, TMS=0.
  - rsp_valid pulses for exactly 1 cycle with rsp_data held stable.
  - Next cycle returns to IDLE.
- cmd_len rules:
  - len=0 for scan or idle: no TCK activity; rsp_valid pulses 2 cycles after the transfer with rsp_data=0.
  - len>MAX_LEN is clamped to MAX_LEN.
  - cmd_len is ignored for TAP reset.
- Back-to-back commands:
  - Earliest next acceptance is the cycle after rsp_valid.
  - TCK stays low for at least one low phase between commands.
- rst asserted mid-operation:
  - Next edge: outputs return to reset values, the in-flight command is dropped and no rsp_valid is produced.
  - INIT re-runs after rst deasserts.
- TDI=0 outside SHIFT. rsp_data holds its last value until the next SHIFT begins.

Test Plan:
- Reset (CLK_DIV=2): release rst → TMS=1 on 5 TCK rising edges, then 0 on 1; cmd_ready rises within 26 clk cycles; no rsp_valid.
- DR scan (TAP model DR capture=0x3C): len=8, data=0xA5 → TDI on shift edges 1,0,1,0,0,1,0,1; TMS sequence 1,0,0,0×7,1,1,0 (13 periods); rsp_data=0x0000003C with a single-cycle rsp_valid.
- IR scan (TAP IR capture=0b0001): len=4, data=0x2 → TMS 1,1,0,0,0,0,0,1,1,0; TAP IR=0x2 after Update; rsp_data=0x1.
- Boundary lengths: len=0 DR → no TCK edge, rsp_valid 2 cycles after transfer, rsp_data=0. len=40 → exactly 32 shift periods.
- Reset mid-shift: assert rst at DR shift bit 3 → TCK=0 and TMS=1 next cycle; no rsp_valid; INIT sequence repeats; a subsequent DR scan returns correct data.
- Back-to-back: cmd_valid held high for DR then idle-run len=3 → second command accepted the cycle after the first rsp_valid; exactly 3 TMS=0 periods; second rsp_valid follows.

Source files
------------

// File: rtl/jtag_host_driver.sv
// JTAG initiator: runs TAP reset, IR/DR scans and idle runs as single host commands,
// deriving TCK from clk (CLK_DIV clk cycles per half-period) and capturing TDO.
module jtag_host_driver #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [$clog2(MAX_LEN):0] cmd_len,
    input  logic [MAX_LEN-1:0]       cmd_data,
    output logic                     rsp_valid,
    output logic [MAX_LEN-1:0]       rsp_data,
    output logic                     busy,
    output logic                     TCK,
    output logic                     TMS,
    output logic                     TDI,
    input  logic                     TDO
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(2 * CLK_DIV);

    localparam logic [1:0] T_RST = 2'b00;
    localparam logic [1:0] T_IR  = 2'b01;
    localparam logic [1:0] T_DR  = 2'b10;

    typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, DONE} state_t;

    state_t             state_q, state_d, nst;
    logic               act_q, act_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      idx_q, idx_d, nidx;
    logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic [1:0]         typ_q, typ_d;
    logic [LW-1:0]      len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d, rsp_q, rsp_d;

    // Number of TCK periods spent in a state for the latched command.
    function automatic logic [LW-1:0] seq_n(input state_t st, input logic [1:0] ty,
                                            input logic [LW-1:0] ln);
        logic [LW-1:0] n;
        n = '0;
        case (st)
            INIT:  n = LW'(6);
            PRE: begin
                case (ty)
                    T_RST:   n = LW'(6);
                    T_IR:    n = LW'(4);
                    T_DR:    n = LW'(3);
                    default: n = ln;
                endcase
            end
            SHIFT: n = ln;
            POST:  n = LW'(2);
            default: n = '0;
        endcase
        return n;
    endfunction

    function automatic logic seq_tms(input state_t st, input logic [1:0] ty,
                                     input logic [LW-1:0] i, input logic [LW-1:0] ln);
        logic t;
        t = 1'b0;
        case (st)
            INIT: t = (i < LW'(5));
            PRE: begin
                case (ty)
                    T_RST:   t = (i < LW'(5));
                    T_IR:    t = (i < LW'(2));
                    T_DR:    t = (i == '0);
                    default: t = 1'b0;
                endcase
            end
            SHIFT: t = (i == ln - LW'(1));
            POST:  t = (i == '0);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic state_t seq_next(input state_t st, input logic [1:0] ty);
        state_t s;
        case (st)
            PRE:     s = (ty == T_IR || ty == T_DR) ? SHIFT : DONE;
            SHIFT:   s = POST;
            POST:    s = DONE;
            default: s = IDLE;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        typ_d   = typ_q;
        len_d   = len_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
        nidx    = idx_q + LW'(1);
        nst     = seq_next(state_q, typ_q);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    typ_d   = cmd_type;
                    len_d   = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
                    data_d  = cmd_data;
                    state_d = PRE;
                end
            end
            DONE: state_d = IDLE;
            PRE: begin
                // First PRE cycle: zero-length scans/runs skip straight to DONE.
                if (!act_q) begin
                    if (typ_q != T_RST && len_q == '0) begin
                        rsp_d   = '0;
                        state_d = DONE;
                    end else begin
                        act_d = 1'b1;
                        cnt_d = '0;
                        idx_d = '0;
                        tms_d = seq_tms(PRE, typ_q, '0, len_q);
                    end
                end
            end
            default: ;
        endcase

        if (act_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(CLK_DIV - 1)) begin
                tck_d = 1'b1;
                if (state_q == SHIFT) rsp_d[idx_q[IW-1:0]] = TDO;
            end
            // End of high phase: falling edge, and the start of the next low phase.
            if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
                cnt_d = '0;
                tck_d = 1'b0;
                if (nidx < seq_n(state_q, typ_q, len_q)) begin
                    idx_d = nidx;
                    tms_d = seq_tms(state_q, typ_q, nidx, len_q);
                    tdi_d = (state_q == SHIFT) & data_q[nidx[IW-1:0]];
                end else begin
                    state_d = nst;
                    idx_d   = '0;
                    tms_d   = seq_tms(nst, typ_q, '0, len_q);
                    tdi_d   = (nst == SHIFT) & data_q[0];
                    act_d   = (nst == SHIFT) || (nst == POST);
                    if (nst == SHIFT) rsp_d = '0;
                end
            end
        end
    end

    // Reset doubles as the start of the first INIT low phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            act_q   <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            typ_q   <= T_RST;
            len_q   <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            typ_q   <= typ_d;
            len_q   <= len_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Bench for jtag_host_driver: behavioural TAP on the scan side, directed table,
// random commands against a sequence-level model, and reset/back-to-back cases.
module tb_jtag_host_driver;
    localparam int MAX_LEN = 32;
    localparam int CLK_DIV = 2;
    localparam int LW      = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_type = 2'b00;
    logic [LW-1:0] cmd_len = '0;
    logic [31:0]   cmd_data = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic          busy, TCK, TMS, TDI, TDO;

    int n_cmp = 0;
    int n_err = 0;
    int rv_cnt = 0;

    always #5 clk = ~clk;

    jtag_host_driver #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    // Behavioural TAP: 32-bit DR with settable capture, 4-bit IR capturing 0001.
    typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                              SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
    tap_t        ts = RTI;
    logic [31:0] dr_sr = '0;
    logic [31:0] dr_cap = '0;
    logic [3:0]  ir_sr = '0;
    logic [3:0]  ir = '0;
    bit tms_log[$], tdi_log[$], exp_tms[$], exp_tdi[$];

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    assign TDO = (ts == SHDR) ? dr_sr[0] : (ts == SHIR) ? ir_sr[0] : 1'b0;

    always @(posedge TCK) begin
        tms_log.push_back(TMS);
        tdi_log.push_back(TDI);
        case (ts)
            CDR:  dr_sr <= dr_cap;
            SHDR: dr_sr <= {TDI, dr_sr[31:1]};
            CIR:  ir_sr <= 4'b0001;
            SHIR: ir_sr <= {TDI, ir_sr[3:1]};
            UIR:  ir <= ir_sr;
            TLR:  ir <= 4'hF;
            default: ;
        endcase
        ts <= tap_next(ts, TMS);
    end

    always @(negedge clk) if (rsp_valid === 1'b1) rv_cnt <= rv_cnt + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] packq(input bit q[$]);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < q.size() && i < 128; i++) v[i] = q[i];
        return v;
    endfunction

    function automatic void push_exp(input bit m, input bit t);
        exp_tms.push_back(m);
        exp_tdi.push_back(t);
    endfunction

    // Command-level model: expected TMS/TDI per TCK period and the response word.
    function automatic logic [31:0] model(input logic [1:0] ty, input int ln,
                                          input logic [31:0] d, input logic [31:0] cap,
                                          input logic [31:0] prev);
        int L;
        logic [31:0] r;
        L = (ln > MAX_LEN) ? MAX_LEN : ln;
        exp_tms.delete();
        exp_tdi.delete();
        r = prev;
        if (ty == 2'b00) begin
            for (int i = 0; i < 6; i++) push_exp(i < 5, 1'b0);
        end else if (ty == 2'b11) begin
            for (int i = 0; i < L; i++) push_exp(1'b0, 1'b0);
            if (L == 0) r = '0;
        end else if (L == 0) begin
            r = '0;
        end else begin
            push_exp(1'b1, 1'b0);
            if (ty == 2'b01) push_exp(1'b1, 1'b0);
            push_exp(1'b0, 1'b0);
            push_exp(1'b0, 1'b0);
            r = '0;
            for (int i = 0; i < L; i++) begin
                push_exp(i == L - 1, d[i]);
                if (ty == 2'b10) r[i] = cap[i];
                else r[i] = (i < 4) ? (i == 0) : d[i-4];
            end
            push_exp(1'b1, 1'b0);
            push_exp(1'b0, 1'b0);
        end
        return r;
    endfunction

    task automatic do_cmd(input logic [1:0] ty, input int ln, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
        int w;
        rd = '0;
        w = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && w < 3000) begin @(negedge clk); w++; end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_type = ty; cmd_len = LW'(ln); cmd_data = d;
        tms_log.delete(); tdi_log.delete();
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 3000) begin @(negedge clk); lat++; end
        chk("rsp_valid_seen", rsp_valid, 1'b1);
        rd = rsp_data;
        @(negedge clk);
        chk("rsp_pulse_1cyc", rsp_valid, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        int w, rv0;
        rv0 = rv_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tck", TCK, 1'b0);
        chk("rst_tms", TMS, 1'b1);
        chk("rst_tdi", TDI, 1'b0);
        chk("rst_ready_valid_busy", {cmd_ready, rsp_valid, busy}, 3'b001);
        chk("rst_rsp_data", rsp_data, 32'h0);
        repeat (hold) @(negedge clk);
        rst = 1'b0;
        tms_log.delete(); tdi_log.delete();
        w = 0;
        while (cmd_ready !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        chk("init_ready_within_26", (cmd_ready === 1'b1) && (w <= 26), 1'b1);
        chk("init_tms_count", tms_log.size(), 6);
        chk("init_tms_seq", packq(tms_log), 128'h1F);
        chk("init_tap_rti", ts, RTI);
        chk("init_no_rsp", rv_cnt, rv0);
        chk("idle_tck_low", TCK, 1'b0);
    endtask

    typedef struct {
        logic [1:0]  ty;
        int          ln;
        logic [31:0] d;
        logic [31:0] cap;
        logic [31:0] rsp;
        int          np;
        logic [3:0]  ir;
    } vec_t;

    initial begin
        vec_t        tbl[9];
        logic [31:0] erm, rd, d, cap;
        logic [1:0]  ty;
        int          lat, ln, w;

        tbl[0] = '{2'b10,  8, 32'h000000A5, 32'h0000003C, 32'h0000003C, 13, 4'hF};
        tbl[1] = '{2'b01,  4, 32'h00000002, 32'h0000003C, 32'h00000001, 10, 4'h2};
        tbl[2] = '{2'b10,  0, 32'h0000FFFF, 32'h0000003C, 32'h00000000,  0, 4'h2};
        tbl[3] = '{2'b10, 40, 32'h12345678, 32'h0000003C, 32'h0000003C, 37, 4'h2};
        tbl[4] = '{2'b00,  7, 32'h00000000, 32'h0000003C, 32'h0000003C,  6, 4'hF};
        tbl[5] = '{2'b11,  5, 32'h00000000, 32'h0000003C, 32'h0000003C,  5, 4'hF};
        tbl[6] = '{2'b01, 12, 32'h00000ABC, 32'h0000003C, 32'h00000BC1, 18, 4'hA};
        tbl[7] = '{2'b11,  0, 32'h00000000, 32'h0000003C, 32'h00000000,  0, 4'hA};
        tbl[8] = '{2'b10, 32, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF, 37, 4'hA};

        do_reset(3);
        erm = '0;

        for (int k = 0; k < 9; k++) begin
            dr_cap = tbl[k].cap;
            erm = model(tbl[k].ty, tbl[k].ln, tbl[k].d, tbl[k].cap, erm);
            do_cmd(tbl[k].ty, tbl[k].ln, tbl[k].d, rd, lat);
            chk($sformatf("v%0d_rsp", k), rd, tbl[k].rsp);
            chk($sformatf("v%0d_periods", k), tms_log.size(), tbl[k].np);
            chk($sformatf("v%0d_tms", k), packq(tms_log), packq(exp_tms));
            chk($sformatf("v%0d_tdi", k), packq(tdi_log), packq(exp_tdi));
            chk($sformatf("v%0d_ir", k), ir, tbl[k].ir);
            chk($sformatf("v%0d_tap", k), ts, RTI);
            if (tbl[k].np == 0) chk($sformatf("v%0d_len0_latency", k), lat, 2);
        end

        for (int k = 0; k < 40; k++) begin
            ty  = 2'($urandom_range(0, 3));
            ln  = (k % 5 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 40);
            d   = $urandom;
            cap = $urandom;
            dr_cap = cap;
            erm = model(ty, ln, d, cap, erm);
            do_cmd(ty, ln, d, rd, lat);
            chk($sformatf("r%0d_rsp", k), rd, erm);
            chk($sformatf("r%0d_periods", k), tms_log.size(), exp_tms.size());
            chk($sformatf("r%0d_tms", k), packq(tms_log), packq(exp_tms));
            chk($sformatf("r%0d_tdi", k), packq(tdi_log), packq(exp_tdi));
            chk($sformatf("r%0d_tap", k), ts, RTI);
        end

        // Reset during DR shift bit 3.
        @(negedge clk);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 3000) begin @(negedge clk); w++; end
        dr_cap = 32'h0000003C;
        cmd_valid = 1'b1; cmd_type = 2'b10; cmd_len = 6'd8; cmd_data = 32'hA5;
        tms_log.delete(); tdi_log.delete();
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (tms_log.size() < 7 && w < 500) begin @(negedge clk); w++; end
        chk("mid_reached_bit3", tms_log.size(), 7);
        do_reset(2);
        erm = model(2'b10, 8, 32'hA5, dr_cap, 32'h0);
        do_cmd(2'b10, 8, 32'hA5, rd, lat);
        chk("post_rst_rsp", rd, erm);
        chk("post_rst_tms", packq(tms_log), packq(exp_tms));
        chk("post_rst_tdi", packq(tdi_log), packq(exp_tdi));

        // Back-to-back: valid held high, DR scan then idle run of 3.
        @(negedge clk);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 3000) begin @(negedge clk); w++; end
        dr_cap = 32'h0F0F1234;
        erm = model(2'b10, 8, 32'h5A, dr_cap, erm);
        cmd_valid = 1'b1; cmd_type = 2'b10; cmd_len = 6'd8; cmd_data = 32'h5A;
        tms_log.delete(); tdi_log.delete();
        @(negedge clk);
        cmd_type = 2'b11; cmd_len = 6'd3;
        w = 0;
        while (rsp_valid !== 1'b1 && w < 3000) begin @(negedge clk); w++; end
        chk("b2b_rsp1_valid", rsp_valid, 1'b1);
        chk("b2b_rsp1", rsp_data, erm);
        chk("b2b_tms1", packq(tms_log), packq(exp_tms));
        chk("b2b_not_ready_at_rsp", cmd_ready, 1'b0);
        erm = model(2'b11, 3, 32'h0, dr_cap, erm);
        @(negedge clk);
        chk("b2b_ready_next", cmd_ready, 1'b1);
        chk("b2b_tck_low_gap", TCK, 1'b0);
        tms_log.delete(); tdi_log.delete();
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_second_accepted", busy, 1'b1);
        w = 0;
        while (rsp_valid !== 1'b1 && w < 3000) begin @(negedge clk); w++; end
        chk("b2b_rsp2_valid", rsp_valid, 1'b1);
        chk("b2b_rsp2", rsp_data, erm);
        chk("b2b_idle_periods", tms_log.size(), 3);
        chk("b2b_idle_tms", packq(tms_log), packq(exp_tms));
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
